// File: rtl/ex_div_pkg.sv
// Shared definitions for the EX-stage divider: width, state encoding, polarity constants, helpers.
package ex_div_pkg;

  localparam int DIV_WIDTH = 32;

  localparam logic STALLREQ_ENABLE  = 1'b1;
  localparam logic STALLREQ_DISABLE = 1'b0;
  localparam logic RST_ENABLE       = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_DIVZERO = 2'b01,
    S_ON      = 2'b10,
    S_DONE    = 2'b11
  } div_state_e;

  // Two's-complement negation when en is set, pass-through otherwise.
  function automatic logic [DIV_WIDTH-1:0] neg_if(input logic [DIV_WIDTH-1:0] v, input logic en);
    logic [DIV_WIDTH-1:0] r;
    if (en) begin
      r = ~v + 32'd1;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/ex_div_step.sv
// One restoring shift-subtract step: shifts the next dividend bit into the partial remainder.
module div_step
  import ex_div_pkg::*;
(
  input  logic [DIV_WIDTH:0]   i_rem,
  input  logic                 i_bit,
  input  logic [DIV_WIDTH-1:0] i_divisor,
  output logic [DIV_WIDTH:0]   o_rem,
  output logic                 o_qbit
);

  logic [DIV_WIDTH+1:0] w_shift;
  logic [DIV_WIDTH+1:0] w_diff;

  // Trial subtraction; a borrow out of the top bit restores the shifted remainder.
  always_comb begin
    w_shift = {i_rem, i_bit};
    w_diff  = w_shift - {2'b00, i_divisor};
    if (w_diff[DIV_WIDTH+1]) begin
      o_rem  = w_shift[DIV_WIDTH:0];
      o_qbit = 1'b0;
    end else begin
      o_rem  = w_diff[DIV_WIDTH:0];
      o_qbit = 1'b1;
    end
  end

endmodule

// File: rtl/ex_div.sv
// Multi-cycle 32-bit restoring divider for the EX stage; signed support under DIV_SIGNED_EN.
module ex_div
  import ex_div_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic                   signed_i,
  input  logic [DIV_WIDTH-1:0]   dividend_i,
  input  logic [DIV_WIDTH-1:0]   divisor_i,
  input  logic                   cancel_i,
  output logic [2*DIV_WIDTH-1:0] result_o,
  output logic                   ready_o,
  output logic                   stallreq_o
);

  div_state_e             r_state;
  logic [4:0]             r_count;
  logic [DIV_WIDTH:0]     r_rem;
  logic [DIV_WIDTH-1:0]   r_quot;
  logic [DIV_WIDTH-1:0]   r_divisor;
  logic [2*DIV_WIDTH-1:0] r_result;
  logic                   r_ready;

  logic [DIV_WIDTH:0]     w_step_rem;
  logic                   w_step_qbit;
  logic [DIV_WIDTH-1:0]   w_dvd_mag;
  logic [DIV_WIDTH-1:0]   w_dvs_mag;
  logic [DIV_WIDTH-1:0]   w_quot_fix;
  logic [DIV_WIDTH-1:0]   w_rem_fix;

`ifdef DIV_SIGNED_EN
  logic r_neg_q;
  logic r_neg_r;
  logic w_sgn_a;
  logic w_sgn_b;

  assign w_sgn_a    = signed_i & dividend_i[DIV_WIDTH-1];
  assign w_sgn_b    = signed_i & divisor_i[DIV_WIDTH-1];
  assign w_dvd_mag  = neg_if(dividend_i, w_sgn_a);
  assign w_dvs_mag  = neg_if(divisor_i, w_sgn_b);
  assign w_quot_fix = neg_if(r_quot, r_neg_q);
  assign w_rem_fix  = neg_if(r_rem[DIV_WIDTH-1:0], r_neg_r);
`else
  logic w_unused_signed;

  assign w_unused_signed = signed_i;
  assign w_dvd_mag       = dividend_i;
  assign w_dvs_mag       = divisor_i;
  assign w_quot_fix      = r_quot;
  assign w_rem_fix       = r_rem[DIV_WIDTH-1:0];
`endif

  // r_quot doubles as the dividend shift register: its MSB feeds the step, quotient bits enter at the LSB.
  div_step u_step (
    .i_rem     (r_rem),
    .i_bit     (r_quot[DIV_WIDTH-1]),
    .i_divisor (r_divisor),
    .o_rem     (w_step_rem),
    .o_qbit    (w_step_qbit)
  );

  // Control FSM with datapath; cancel or a dropped start abandons the operation.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      r_state   <= S_IDLE;
      r_count   <= 5'd0;
      r_rem     <= 33'd0;
      r_quot    <= 32'd0;
      r_divisor <= 32'd0;
      r_result  <= 64'd0;
      r_ready   <= 1'b0;
`ifdef DIV_SIGNED_EN
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
`endif
    end else if (cancel_i || (!start_i && r_state != S_IDLE)) begin
      r_state  <= S_IDLE;
      r_count  <= 5'd0;
      r_result <= 64'd0;
      r_ready  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ready  <= 1'b0;
          r_result <= 64'd0;
          r_count  <= 5'd0;
          if (start_i) begin
            r_rem     <= 33'd0;
            r_quot    <= w_dvd_mag;
            r_divisor <= w_dvs_mag;
`ifdef DIV_SIGNED_EN
            r_neg_q   <= w_sgn_a ^ w_sgn_b;
            r_neg_r   <= w_sgn_a;
`endif
            if (divisor_i == 32'd0) begin
              r_state <= S_DIVZERO;
            end else begin
              r_state <= S_ON;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_DIVZERO: begin
          // Remainder sign fixup restores the original dividend from its magnitude.
          r_rem   <= {1'b0, r_quot};
          r_quot  <= 32'hFFFF_FFFF;
`ifdef DIV_SIGNED_EN
          r_neg_q <= 1'b0;
`endif
          r_state <= S_DONE;
        end
        S_ON: begin
          r_rem  <= w_step_rem;
          r_quot <= {r_quot[DIV_WIDTH-2:0], w_step_qbit};
          if (r_count == 5'd31) begin
            r_state <= S_DONE;
          end else begin
            r_count <= r_count + 5'd1;
            r_state <= S_ON;
          end
        end
        S_DONE: begin
          r_ready  <= 1'b1;
          r_result <= {w_rem_fix, w_quot_fix};
          r_state  <= S_DONE;
        end
        default: begin
          r_state  <= S_IDLE;
          r_count  <= 5'd0;
          r_result <= 64'd0;
          r_ready  <= 1'b0;
        end
      endcase
    end
  end

  assign result_o   = r_result;
  assign ready_o    = r_ready;
  assign stallreq_o = (start_i & ~r_ready) ? STALLREQ_ENABLE : STALLREQ_DISABLE;

endmodule
